// File: rtl/hazard_ctrl.sv
// Pipeline hold/flush/bubble generator: load-use detection, jump/branch squash, memory-wait freeze.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall/flush/wait performance counters.
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic [4:0] ex_rd_addr,
   input  logic       ex_mem_read,
   input  logic       ex_reg_write,
   input  logic       jb,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_hold,
   output logic       if_id_hold,
   output logic       if_id_flush,
   output logic       id_ex_hold,
   output logic       id_ex_stall,
   output logic       ex_mem_hold,
   output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count,
   output logic [31:0] wait_cycles
`endif
);

   typedef enum logic [1:0] {S_RUN = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2} state_t;

   localparam bit               WDOG_EN   = (MEM_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t           state_r, state_n;
   logic [CNT_W-1:0] wait_cnt_r, wait_cnt_n;
   logic             jb_pending_r, jb_pending_n;
   logic             freeze_s, flush_now_s, load_use_s, rs1_hit_s, rs2_hit_s;

   always_comb begin
      freeze_s    = (state_r == S_ERR) | (mem_req & ~mem_ready);
      flush_now_s = ~freeze_s & (jb | jb_pending_r);
      rs1_hit_s   = id_use_rs1 & (id_rs1_addr == ex_rd_addr);
      rs2_hit_s   = id_use_rs2 & (id_rs2_addr == ex_rd_addr);
      load_use_s  = ~freeze_s & ~flush_now_s & ex_mem_read & ex_reg_write
                    & (ex_rd_addr != 5'd0) & (rs1_hit_s | rs2_hit_s);
   end

   // Outputs are combinational but forced low for the whole time rst is asserted.
   always_comb begin
      pc_hold     = 1'b0;
      if_id_hold  = 1'b0;
      if_id_flush = 1'b0;
      id_ex_hold  = 1'b0;
      id_ex_stall = 1'b0;
      ex_mem_hold = 1'b0;
      mem_err     = 1'b0;
      if (rst) begin
         pc_hold = 1'b0;
      end else begin
         pc_hold     = freeze_s | load_use_s;
         if_id_hold  = freeze_s | load_use_s;
         if_id_flush = flush_now_s;
         id_ex_hold  = freeze_s;
         id_ex_stall = flush_now_s | load_use_s;
         ex_mem_hold = freeze_s;
         mem_err     = (state_r == S_ERR);
      end
   end

   always_comb begin
      state_n    = state_r;
      wait_cnt_n = wait_cnt_r;
      case (state_r)
         S_RUN: begin
            if (mem_req & ~mem_ready) begin
               state_n    = S_WAIT;
               wait_cnt_n = CNT_ONE;
            end else begin
               state_n = S_RUN;
            end
         end
         S_WAIT: begin
            if (~mem_req | mem_ready) begin
               state_n    = S_RUN;
               wait_cnt_n = CNT_ZERO;
            end else if (WDOG_EN && (wait_cnt_r == TIMEOUT_C)) begin
               state_n = S_ERR;
            end else if (wait_cnt_r != CNT_MAX) begin
               wait_cnt_n = wait_cnt_r + CNT_ONE;
            end else begin
               wait_cnt_n = wait_cnt_r;
            end
         end
         S_ERR: begin
            state_n = S_ERR;
         end
         default: begin
            state_n    = S_RUN;
            wait_cnt_n = CNT_ZERO;
         end
      endcase
      // A redirect seen while frozen is remembered once and replayed when the pipe moves.
      if (flush_now_s) begin
         jb_pending_n = 1'b0;
      end else if (jb & freeze_s & (state_r != S_ERR)) begin
         jb_pending_n = 1'b1;
      end else begin
         jb_pending_n = jb_pending_r;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_RUN;
         wait_cnt_r   <= CNT_ZERO;
         jb_pending_r <= 1'b0;
      end else begin
         state_r      <= state_n;
         wait_cnt_r   <= wait_cnt_n;
         jb_pending_r <= jb_pending_n;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      if (en && (v != 32'hFFFF_FFFF)) begin
         return v + 32'd1;
      end else begin
         return v;
      end
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 32'd0;
         flush_count  <= 32'd0;
         wait_cycles  <= 32'd0;
      end else begin
         stall_cycles <= sat_inc(stall_cycles, load_use_s);
         flush_count  <= sat_inc(flush_count, flush_now_s);
         wait_cycles  <= sat_inc(wait_cycles, freeze_s & (state_r != S_ERR));
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl with MEM_TIMEOUT=4.
// Covers reset gating, load-use, flush, memory wait, watchdog, pending flush and perf counters.
module tb_hazard_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write, jb, mem_req, mem_ready;
   logic       pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_stall, ex_mem_hold, mem_err;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count, wait_cycles;
`endif

   int checks = 0;
   int errors = 0;
   logic [6:0] exp_q[$];
   string      tag_q[$];

   // {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_stall, ex_mem_hold, mem_err}
   localparam logic [6:0] E_IDLE  = 7'b0000000;
   localparam logic [6:0] E_LU    = 7'b1100100;
   localparam logic [6:0] E_FLUSH = 7'b0010100;
   localparam logic [6:0] E_FRZ   = 7'b1101010;
   localparam logic [6:0] E_ERR   = 7'b1101011;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
      .jb(jb), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
      .id_ex_hold(id_ex_hold), .id_ex_stall(id_ex_stall), .ex_mem_hold(ex_mem_hold),
      .mem_err(mem_err)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .flush_count(flush_count), .wait_cycles(wait_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic clr();
      id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
      jb = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd_addr = rd;
      id_rs1_addr = rs1; id_use_rs1 = u1; id_rs2_addr = rs2; id_use_rs2 = u2;
   endtask

   task automatic check_pop();
      logic [6:0] got, e;
      string t;
      got = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_stall, ex_mem_hold, mem_err};
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (got === e) else begin
         errors++;
         $error("FAIL %s got=%b exp=%b", t, got, e);
      end
   endtask

   // Push expectation with the stimulus, compare at the negedge, advance one cycle.
   task automatic cyc(input logic [6:0] e, input string tag);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      check_pop();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input logic [31:0] got, input logic [31:0] e, input string tag);
      checks++;
      assert (got === e) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, e);
      end
   endtask

   initial begin
      clr();
      rst = 1'b1; jb = 1'b1; mem_req = 1'b1;
      set_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
      cyc(E_IDLE, "reset_gate");
      clr();
      cyc(E_IDLE, "reset_idle");
      rst = 1'b0;
      cyc(E_IDLE, "idle");

      set_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
      cyc(E_LU, "lu_rs2");
      clr();
      cyc(E_IDLE, "lu_done");
      set_lu(5'd7, 5'd7, 1'b1, 5'd1, 1'b0);
      cyc(E_LU, "lu_rs1");
      set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      cyc(E_IDLE, "lu_x0");
      set_lu(5'd9, 5'd9, 1'b0, 5'd9, 1'b0);
      cyc(E_IDLE, "lu_unused");
      set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
      ex_reg_write = 1'b0;
      cyc(E_IDLE, "lu_nowrite");
      clr();

      jb = 1'b1;
      cyc(E_FLUSH, "flush");
      clr();
      cyc(E_IDLE, "flush_once");
      set_lu(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
      jb = 1'b1;
      cyc(E_FLUSH, "flush_over_lu");
      clr();

      mem_req = 1'b1;
      cyc(E_FRZ, "wait1");
      cyc(E_FRZ, "wait2");
      cyc(E_FRZ, "wait3");
      mem_ready = 1'b1;
      cyc(E_IDLE, "wait_ready");
      clr();
      cyc(E_IDLE, "wait_run");

      mem_req = 1'b1;
      set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
      cyc(E_FRZ, "pend_w1_lu");
      clr(); mem_req = 1'b1; jb = 1'b1;
      cyc(E_FRZ, "pend_w2_jb");
      cyc(E_FRZ, "pend_w3_jb");
      jb = 1'b0; mem_ready = 1'b1;
      cyc(E_FLUSH, "pend_flush");
      clr();
      cyc(E_IDLE, "pend_clear");

      mem_req = 1'b1;
      for (int i = 0; i < 5; i++) cyc(E_FRZ, $sformatf("tmo_w%0d", i + 1));
      cyc(E_ERR, "tmo_err");
      mem_req = 1'b0;
      cyc(E_ERR, "err_sticky");
      jb = 1'b1; mem_ready = 1'b1;
      cyc(E_ERR, "err_jb");
      clr(); rst = 1'b1;
      cyc(E_IDLE, "err_rst");
      rst = 1'b0;
      cyc(E_IDLE, "after_rst");

      mem_req = 1'b1;
      cyc(E_FRZ, "mid_wait");
      rst = 1'b1;
      cyc(E_IDLE, "mid_wait_rst");
      rst = 1'b0; clr();
      cyc(E_IDLE, "mid_wait_after");

      set_lu(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
      cyc(E_LU, "perf_lu1");
      set_lu(5'd8, 5'd0, 1'b0, 5'd8, 1'b1);
      cyc(E_LU, "perf_lu2");
      clr(); jb = 1'b1;
      cyc(E_FLUSH, "perf_flush");
      clr(); mem_req = 1'b1;
      cyc(E_FRZ, "perf_w1");
      cyc(E_FRZ, "perf_w2");
      cyc(E_FRZ, "perf_w3");
      mem_ready = 1'b1;
      cyc(E_IDLE, "perf_ready");
      clr();
`ifdef HAZARD_PERF_CNT_EN
      chk32(stall_cycles, 32'd2, "stall_cycles");
      chk32(flush_count, 32'd1, "flush_count");
      chk32(wait_cycles, 32'd3, "wait_cycles");
`endif
      cyc(E_IDLE, "final_idle");

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline-control generator for the 5-stage RISC-V core; produces the hold, flush and bubble signals consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards, squashes wrong-path instructions on taken jump/branch, and freezes the whole pipeline while data memory is not ready.
- Contains a memory-wait FSM with a timeout watchdog and a pending-flush latch.

Parameters:
- MEM_TIMEOUT, 16, max consecutive waiting cycles before error; 0 disables the watchdog.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- id_rs1_addr  input  5  rs1 index of instruction in ID
- id_rs2_addr  input  5  rs2 index of instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- ex_rd_addr  input  5  rd index of instruction in EX
- ex_mem_read  input  1  EX instruction is a load
- ex_reg_write  input  1  EX instruction writes rd
- jb  input  1  one-cycle pulse: jump or taken branch resolved in EX
- mem_req  input  1  MEM stage has an active data-memory access
- mem_ready  input  1  data memory completes access this cycle
- pc_hold  output  1  PC keeps its value
- if_id_hold  output  1  IF/ID keeps its contents
- if_id_flush  output  1  IF/ID loads NOP
- id_ex_hold  output  1  ID/EX keeps its contents
- id_ex_stall  output  1  ID/EX loads zeros (bubble/flush)
- ex_mem_hold  output  1  EX/MEM keeps its contents
- mem_err  output  1  memory timeout; sticky until rst

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- State: fsm in {RUN, WAIT, ERR}, wait_cnt[CNT_W-1:0], jb_pending.
- Reset (rst=1 at a rising edge): fsm=RUN, wait_cnt=0, jb_pending=0.
  - While rst is high, all outputs are 0. This also holds when rst is asserted mid-wait or in ERR.
- Combinational terms per cycle:
  - freeze = (fsm==ERR) | (mem_req & ~mem_ready)
  - flush_now = ~freeze & (jb | jb_pending)
  - load_use = ~freeze & ~flush_now & ex_mem_read & ex_reg_write & (ex_rd_addr!=0) & ((id_use_rs1 & id_rs1_addr==ex_rd_addr) | (id_use_rs2 & id_rs2_addr==ex_rd_addr))
- Outputs, all combinational and valid in the same cycle:
  - pc_hold = if_id_hold = freeze | load_use
  - if_id_flush = flush_now
  - id_ex_hold = ex_mem_hold = freeze
  - id_ex_stall = flush_now | load_use
  - mem_err = (fsm==ERR)
- Priority: rst > freeze > flush > load-use.
  - jb together with a load-use hazard: flush only, no stall.
  - The x0 destination never creates a hazard.
- Load-use costs exactly 1 bubble cycle; no state is needed because the load moves to MEM on the next edge.
- FSM transitions:
  - RUN: if mem_req & ~mem_ready, go to WAIT with wait_cnt=1; else stay.
  - WAIT: if ~mem_req | mem_ready, go to RUN with wait_cnt=0. Else, if MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT, go to ERR. Else wait_cnt+1.
  - ERR: stays until rst; pipeline frozen permanently.
- Watchdog timing: mem_err rises after MEM_TIMEOUT+1 consecutive not-ready cycles. With MEM_TIMEOUT=0 there is no ERR, and the counter saturates at all-ones.
- jb_pending:
  - Set when jb=1 and freeze=1 and fsm!=ERR.
  - Cleared in any cycle where flush_now=1.
  - A jb arriving while jb_pending is already set is absorbed, not doubled.
  - The flush is applied in the first unfrozen cycle.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds three outputs:
  - stall_cycles [31:0]: count of load_use cycles.
  - flush_count [31:0]: count of flush_now cycles.
  - wait_cycles [31:0]: count of freeze cycles with fsm!=ERR.
  - All three are registered, reset to 0, increment by 1 per qualifying cycle, saturate at 32'hFFFFFFFF, and are visible the cycle after the event.
- When not defined, these ports and registers do not exist, and the remaining behaviour is identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → same cycle pc_hold=1, if_id_hold=1, id_ex_stall=1; next cycle (load moved on) all 0. Repeat with ex_rd=0 → no stall.
- Branch flush: jb pulse with no memory wait → if_id_flush=1 and id_ex_stall=1 for exactly 1 cycle, pc_hold=0. jb together with load-use → flush only, pc_hold=0.
- Memory wait, MEM_TIMEOUT=4: mem_req=1 with mem_ready low 3 cycles, then high → all holds=1 for 3 cycles, mem_err=0, fsm back to RUN with wait_cnt=0.
- Timeout, MEM_TIMEOUT=4: mem_ready held low → mem_err=1 after 5 wait cycles and stays 1 with mem_req dropped; assert rst → mem_err=0 and all outputs 0 next cycle.
- Pending flush: jb pulse during the 2nd cycle of a 3-cycle wait → no flush during the wait; if_id_flush=1 in the first cycle after mem_ready, then jb_pending clears.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls, 1 flush, 3 wait cycles → stall_cycles=2, flush_count=1, wait_cycles=3.
